// File: rtl/poly_chord_trigger.sv
// poly_chord_trigger: debounced chord gate, per-voice frequency derivation,
// optional strum sequencing and a saturating serial voice mixer.
module poly_chord_trigger #(
  parameter int NUM_VOICES      = 3,
  parameter int DATA_BITS       = 12,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int STRUM_TICKS     = 0,
  parameter int MIX_SHIFT       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic                             gate_n_in,
  input  logic [15:0]                      root_freq,
  input  logic [1:0]                       chord_mode,
  output logic [NUM_VOICES-1:0]            voice_gate,
  output logic [16*NUM_VOICES-1:0]         voice_freq,
  input  logic [DATA_BITS*NUM_VOICES-1:0]  voice_din,
  output logic signed [DATA_BITS-1:0]      mix_out,
  output logic                             mix_valid
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (STRUM_TICKS > 0) ? $clog2(STRUM_TICKS + 1) : 1;
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MW = $clog2(NUM_VOICES + 1);
  localparam int AW = DATA_BITS + 3;

  localparam logic signed [AW-1:0] C_MAX = {4'b0000, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [AW-1:0] C_MIN = {4'b1111, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_STRUM, ST_HOLD} state_t;

  genvar gi;

  // The inversion stage is registered, giving three flops between pin and counter.
  logic            r_sync1, r_sync2, r_s, r_deb;
  logic [DW-1:0]   r_deb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_s       <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= gate_n_in;
      r_sync2 <= r_sync1;
      r_s     <= ~r_sync2;
      if (r_s == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb     <= r_s;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  function automatic logic [9:0] f_mult(input logic [1:0] mode, input int j);
    logic [9:0] m;
    m = 10'd256;
    case (mode)
      2'b00:   m = (j == 0) ? 10'd256 : (j == 1) ? 10'd323 : 10'd384;
      2'b01:   m = (j == 0) ? 10'd256 : (j == 1) ? 10'd304 : 10'd384;
      2'b10:   m = (j == 0) ? 10'd256 : (j == 1) ? 10'd384 : 10'd512;
      default: m = 10'd256;
    endcase
    return m;
  endfunction

  logic [16*NUM_VOICES-1:0] w_freq;

  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_freq
      logic [26:0] w_scaled;
      assign w_scaled = ((27'(root_freq) * 27'(f_mult(chord_mode, gi % 3))) >> 8) << (gi / 3);
      assign w_freq[16*gi +: 16] = (w_scaled > 27'h00FFFF) ? 16'hFFFF : w_scaled[15:0];
    end
  endgenerate

  state_t                   r_state, w_state_next;
  logic [NUM_VOICES-1:0]    r_gate, w_gate_next;
  logic [SW-1:0]            r_strum_cnt, w_strum_cnt_next;
  logic [IW-1:0]            r_idx, w_idx_next;
  logic [16*NUM_VOICES-1:0] r_voice_freq;
  logic                     w_latch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gate       <= '0;
      r_strum_cnt  <= '0;
      r_idx        <= '0;
      r_voice_freq <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gate      <= w_gate_next;
      r_strum_cnt <= w_strum_cnt_next;
      r_idx       <= w_idx_next;
      if (w_latch) r_voice_freq <= w_freq;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_gate_next      = r_gate;
    w_strum_cnt_next = r_strum_cnt;
    w_idx_next       = r_idx;
    w_latch          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_deb) begin
          w_latch          = 1'b1;
          w_strum_cnt_next = '0;
          if (STRUM_TICKS == 0 || NUM_VOICES == 1) begin
            w_gate_next  = '1;
            w_state_next = ST_HOLD;
          end else begin
            w_gate_next  = NUM_VOICES'(1);
            w_idx_next   = IW'(1);
            w_state_next = ST_STRUM;
          end
        end
      end
      ST_STRUM: begin
        // Release always wins over a pending strum step.
        if (!r_deb) begin
          w_gate_next  = '0;
          w_state_next = ST_IDLE;
        end else if (sample_tick) begin
          if (r_strum_cnt == SW'(STRUM_TICKS - 1)) begin
            w_gate_next      = r_gate | (NUM_VOICES'(1) << r_idx);
            w_strum_cnt_next = '0;
            w_idx_next       = r_idx + IW'(1);
            if (r_idx == IW'(NUM_VOICES - 1)) w_state_next = ST_HOLD;
          end else begin
            w_strum_cnt_next = r_strum_cnt + SW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!r_deb) begin
          w_gate_next  = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  logic signed [DATA_BITS-1:0] w_din [NUM_VOICES];

  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_din
      assign w_din[gi] = voice_din[DATA_BITS*gi +: DATA_BITS];
    end
  endgenerate

  logic                        r_busy;
  logic [MW-1:0]               r_mix_cnt;
  logic signed [AW-1:0]        r_acc;
  logic signed [DATA_BITS-1:0] r_cap [NUM_VOICES];
  logic signed [DATA_BITS-1:0] r_mix_out;
  logic                        r_mix_valid;
  logic signed [AW-1:0]        w_shifted;
  logic signed [DATA_BITS-1:0] w_sat;

  assign w_shifted = r_acc >>> MIX_SHIFT;
  assign w_sat = (w_shifted > C_MAX) ? C_MAX[DATA_BITS-1:0] :
                 (w_shifted < C_MIN) ? C_MIN[DATA_BITS-1:0] : w_shifted[DATA_BITS-1:0];

  // One voice is accumulated per clock; the count reaching NUM_VOICES marks the output cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_mix_cnt   <= '0;
      r_acc       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) r_cap[k] <= '0;
    end else begin
      r_mix_valid <= 1'b0;
      if (!r_busy) begin
        if (sample_tick) begin
          r_busy    <= 1'b1;
          r_mix_cnt <= '0;
          r_acc     <= '0;
          for (int k = 0; k < NUM_VOICES; k++) r_cap[k] <= w_din[k];
        end
      end else if (r_mix_cnt == MW'(NUM_VOICES)) begin
        r_mix_out   <= w_sat;
        r_mix_valid <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        r_acc     <= r_acc + AW'(r_cap[r_mix_cnt[IW-1:0]]);
        r_mix_cnt <= r_mix_cnt + MW'(1);
      end
    end
  end

  assign voice_gate = r_gate;
  assign voice_freq = r_voice_freq;
  assign mix_out    = r_mix_out;
  assign mix_valid  = r_mix_valid;

endmodule
